// File: rtl/cam_pwr_seq.sv
// cam_pwr_seq: camera power-up / re-init sequencer.
// Powers the camera, waits for the supply to settle, holds the I2C init master
// in reset, then supervises camera init with a timeout. Failed attempts back
// off with power removed and retry a bounded number of times before a sticky
// fault is latched. All timing is counted in 400kHz strobe ticks.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   strobe_400kHz single-cycle timing tick, synchronous to clk
//   enable        level request to power and initialise the camera
//   init_done     pulse from I2C init master on success
//   init_err      pulse from I2C init master on NACK/abort
//   cam_en        camera power enable
//   i2c_reset     active-high reset to the I2C init master
//   cam_ready     camera configured and usable
//   fault         retries exhausted; held until enable drops
//   retry_cnt     failed attempts in the current sequence
//   state_o       encoded FSM state for debug
module cam_pwr_seq #(
  parameter int unsigned PWR_SETTLE_TICKS   = 800,
  parameter int unsigned I2C_HOLD_TICKS     = 8000,
  parameter int unsigned INIT_TIMEOUT_TICKS = 400000,
  parameter int unsigned BACKOFF_TICKS      = 4000,
  parameter int unsigned MAX_RETRY          = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       strobe_400kHz,
  input  logic       enable,
  input  logic       init_done,
  input  logic       init_err,
  output logic       cam_en,
  output logic       i2c_reset,
  output logic       cam_ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_o
);

  localparam int unsigned MAX_AB    = (PWR_SETTLE_TICKS > I2C_HOLD_TICKS) ? PWR_SETTLE_TICKS : I2C_HOLD_TICKS;
  localparam int unsigned MAX_CD    = (INIT_TIMEOUT_TICKS > BACKOFF_TICKS) ? INIT_TIMEOUT_TICKS : BACKOFF_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW        = $clog2(MAX_TICKS) + 1;

  localparam logic [CW-1:0] SETTLE_LAST  = CW'(PWR_SETTLE_TICKS - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(I2C_HOLD_TICKS - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(INIT_TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] BACKOFF_LAST = CW'(BACKOFF_TICKS - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    PWR_SETTLE = 3'd1,
    I2C_HOLD   = 3'd2,
    INIT       = 3'd3,
    READY      = 3'd4,
    BACKOFF    = 3'd5,
    FAULT      = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    retry_nxt;
  logic          expired;
  logic          failed;

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    cnt_nxt   = strobe_400kHz ? cnt + CW'(1) : cnt;
    expired   = 1'b0;
    failed    = 1'b0;

    unique case (state)
      OFF: begin
        cnt_nxt = '0;
        if (enable) state_nxt = PWR_SETTLE;
      end
      PWR_SETTLE: begin
        expired = strobe_400kHz && (cnt == SETTLE_LAST);
        if (expired) state_nxt = I2C_HOLD;
      end
      I2C_HOLD: begin
        expired = strobe_400kHz && (cnt == HOLD_LAST);
        if (expired) state_nxt = INIT;
      end
      INIT: begin
        expired = strobe_400kHz && (cnt == TIMEOUT_LAST);
        // init_done has priority over both init_err and timeout expiry
        if (init_done)                state_nxt = READY;
        else if (init_err || expired) failed    = 1'b1;
      end
      BACKOFF: begin
        expired = strobe_400kHz && (cnt == BACKOFF_LAST);
        if (expired) state_nxt = PWR_SETTLE;
      end
      READY:   cnt_nxt = '0;
      FAULT:   cnt_nxt = '0;
      default: state_nxt = OFF;
    endcase

    if (failed) begin
      if (retry_cnt < RETRY_LIMIT) begin
        state_nxt = BACKOFF;
        if (retry_cnt != 4'hF) retry_nxt = retry_cnt + 4'd1;
      end else begin
        state_nxt = FAULT;
      end
    end

    // Dropping enable aborts everything, including events in the same cycle
    if (!enable && state != OFF) begin
      state_nxt = OFF;
      retry_nxt = '0;
    end

    if (state_nxt != state) cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they change on the transition edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= OFF;
      cnt       <= '0;
      retry_cnt <= '0;
      cam_en    <= 1'b0;
      i2c_reset <= 1'b1;
      cam_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      cam_en    <= (state_nxt == PWR_SETTLE) || (state_nxt == I2C_HOLD) ||
                   (state_nxt == INIT) || (state_nxt == READY);
      i2c_reset <= !((state_nxt == INIT) || (state_nxt == READY));
      cam_ready <= (state_nxt == READY);
      fault     <= (state_nxt == FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// tb_cam_pwr_seq: directed self-checking bench for cam_pwr_seq with short
// tick parameters (settle 4, hold 3, timeout 10, backoff 2, max retry 2) and
// a strobe every 5 clk.
module tb_cam_pwr_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       strobe_400kHz;
  logic       enable;
  logic       init_done;
  logic       init_err;
  logic       cam_en;
  logic       i2c_reset;
  logic       cam_ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  cam_pwr_seq #(
    .PWR_SETTLE_TICKS  (4),
    .I2C_HOLD_TICKS    (3),
    .INIT_TIMEOUT_TICKS(10),
    .BACKOFF_TICKS     (2),
    .MAX_RETRY         (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .strobe_400kHz(strobe_400kHz),
    .enable       (enable),
    .init_done    (init_done),
    .init_err     (init_err),
    .cam_en       (cam_en),
    .i2c_reset    (i2c_reset),
    .cam_ready    (cam_ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: inputs applied at negedge, outputs observed 1ns after posedge
  task automatic cyc(input logic s, input logic d, input logic e);
    @(negedge clk);
    strobe_400kHz = s;
    init_done     = d;
    init_err      = e;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic en,
                            input logic ir, input logic rdy, input logic flt,
                            input logic [3:0] rc);
    check({tag, ".state"},     32'(state_o),   32'(st));
    check({tag, ".cam_en"},    32'(cam_en),    32'(en));
    check({tag, ".i2c_reset"}, 32'(i2c_reset), 32'(ir));
    check({tag, ".cam_ready"}, 32'(cam_ready), 32'(rdy));
    check({tag, ".fault"},     32'(fault),     32'(flt));
    check({tag, ".retry"},     32'(retry_cnt), 32'(rc));
  endtask

  task automatic restart;
    enable = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    enable        = 1'b0;
    strobe_400kHz = 1'b0;
    init_done     = 1'b0;
    init_err      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("idle_off", 32'(state_o), 32'd0);

    // Happy path
    enable = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check_outs("pwr_on", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    ticks(3);
    check("settle_3", 32'(state_o), 32'd1);
    ticks(1);
    check("hold_entry", 32'(state_o), 32'd2);
    ticks(2);
    check("hold_6_i2c", 32'(i2c_reset), 32'd1);
    ticks(1);
    check_outs("init_entry", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    ticks(2);
    cyc(1'b0, 1'b1, 1'b0);
    check_outs("ready", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1);
    check("ready_ignores_err", 32'(state_o), 32'd4);

    // Timeout retries until fault
    restart();
    ticks(7);
    check("to_init", 32'(state_o), 32'd3);
    ticks(9);
    check("to_init_9", 32'(state_o), 32'd3);
    ticks(1);
    check_outs("backoff1", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    ticks(1);
    check("backoff1_hold", 32'(cam_en), 32'd0);
    ticks(1);
    check_outs("resettle1", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
    ticks(17);
    check_outs("backoff2", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    ticks(2 + 7 + 10);
    check_outs("fault", 3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2);
    ticks(3);
    check("fault_sticky", 32'(fault), 32'd1);
    enable = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    check_outs("fault_clr", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    // Error retry then success
    enable = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    ticks(7);
    cyc(1'b0, 1'b0, 1'b1);
    check_outs("err_backoff", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    ticks(2 + 7);
    cyc(1'b0, 1'b1, 1'b0);
    check_outs("err_ready", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);

    // Simultaneous events
    restart();
    ticks(7);
    cyc(1'b0, 1'b1, 1'b1);
    check("done_err_ready", 32'(state_o), 32'd4);
    restart();
    ticks(7);
    ticks(9);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("done_timeout_ready", 32'(state_o), 32'd4);
    restart();
    ticks(7);
    enable = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    check_outs("dis_beats_done", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    // Abort mid-sequence and full restart of settle count
    enable = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    ticks(5);
    check("abort_in_hold", 32'(state_o), 32'd2);
    enable = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    check_outs("abort", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    enable = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    check("strobe_stuck", 32'(state_o), 32'd1);
    ticks(3);
    check("resettle_3", 32'(state_o), 32'd1);
    ticks(1);
    check("resettle_4", 32'(state_o), 32'd2);

    // Async reset from READY
    ticks(3);
    cyc(1'b0, 1'b1, 1'b0);
    check("pre_reset_ready", 32'(cam_ready), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check_outs("async_rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    enable  = 1'b0;
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
